// File: rtl/ddr3_mem_responder_if.sv
// rtl/ddr3_mem_responder_if.sv - DDR3 command/data bus between controller (master) and memory responder (slave)
interface ddr3_mem_responder_if #(
  parameter int BANKS  = 8,
  parameter int ROW_W  = 14,
  parameter int COL_W  = 10,
  parameter int DATA_W = 16
) ();
  localparam int BA_W    = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam int ADDR_W0 = (ROW_W > COL_W) ? ROW_W : COL_W;
  localparam int ADDR_W  = (ADDR_W0 > 11) ? ADDR_W0 : 11;

  logic              cs_n;
  logic              ras_n;
  logic              cas_n;
  logic              we_n;
  logic [BA_W-1:0]   ba;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] dq_in;
  logic [DATA_W-1:0] dq_out;
  logic              dq_oe;

  modport master (
    output cs_n, ras_n, cas_n, we_n, ba, addr, dq_in,
    input  dq_out, dq_oe
  );

  modport slave (
    input  cs_n, ras_n, cas_n, we_n, ba, addr, dq_in,
    output dq_out, dq_oe
  );
endinterface

// File: rtl/ddr3_mem_responder.sv
// rtl/ddr3_mem_responder.sv - DDR3 device-side responder with BL8 burst engine; protocol checks under DDR3_RESP_CHECK_EN
module ddr3_mem_responder #(
  parameter int BANKS  = 8,
  parameter int ROW_W  = 14,
  parameter int COL_W  = 10,
  parameter int DATA_W = 16,
  parameter int CL     = 5,
  parameter int CWL    = 5,
  parameter int MEM_AW = 10
) (
  input  logic                   cpu_clk,
  input  logic                   reset,
  ddr3_mem_responder_if.slave    bus,
  output logic [BANKS-1:0]       bank_open,
  output logic                   err,
  output logic [2:0]             err_code
);
  localparam int BA_W = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam int IDX_W = BA_W + ROW_W + COL_W;
  // Latency minus one is the number of WAIT cycles between command and first beat.
  localparam logic [3:0] RD_WAIT = 4'(CL - 1);
  localparam logic [3:0] WR_WAIT = 4'(CWL - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [2:0]          beat_q, beat_d;
  logic [BA_W-1:0]     b_ba_q, b_ba_d;
  logic [ROW_W-1:0]    b_row_q, b_row_d;
  logic [COL_W-1:0]    b_col_q, b_col_d;
  logic                b_wr_q, b_wr_d;
  logic                b_ap_q, b_ap_d;
  logic [BANKS-1:0]    bank_open_q, bank_open_d;
  logic [ROW_W-1:0]    open_row_q [BANKS];
  logic [ROW_W-1:0]    open_row_d [BANKS];
  logic                err_q, err_d;
  logic [2:0]          err_code_q, err_code_d;
  logic [DATA_W-1:0]   mem_q [2**MEM_AW];

  logic                cmd_act, cmd_rd, cmd_wr, cmd_pre, cmd_ref;
  logic                busy, last_beat, in_flight, ap_close, tgt_open;
  logic                rw_ok, act_ok, pre_ok;
  logic [3:0]          wait_n;
  logic [COL_W-1:0]    col_beat;
  logic [IDX_W-1:0]    idx_full;
  logic [MEM_AW-1:0]   mem_idx;
  logic                mem_we;
  logic                unused_bits;

  // Command decode from the four control pins; anything unlisted is a no-op.
  always_comb begin
    cmd_act = 1'b0;
    cmd_rd  = 1'b0;
    cmd_wr  = 1'b0;
    cmd_pre = 1'b0;
    cmd_ref = 1'b0;
    case ({bus.cs_n, bus.ras_n, bus.cas_n, bus.we_n})
      4'b0011: cmd_act = 1'b1;
      4'b0101: cmd_rd  = 1'b1;
      4'b0100: cmd_wr  = 1'b1;
      4'b0010: cmd_pre = 1'b1;
      4'b0001: cmd_ref = 1'b1;
      default: ;
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign last_beat = (state_q == S_BURST) && (beat_q == 3'd7);
  // On the last beat the burst is finishing, so bank commands are no longer blocked by it.
  assign in_flight = busy && !last_beat;
  assign ap_close  = last_beat && b_ap_q;
  assign tgt_open  = bank_open_q[bus.ba];

`ifdef DDR3_RESP_CHECK_EN
  // Protocol checking: decide which commands execute and which raise an error.
  always_comb begin
    rw_ok      = 1'b0;
    act_ok     = 1'b0;
    pre_ok     = 1'b0;
    err_d      = 1'b0;
    err_code_d = 3'd0;
    if (cmd_rd || cmd_wr) begin
      if (busy) begin
        err_d      = 1'b1;
        err_code_d = 3'd3;
      end else if (!tgt_open) begin
        err_d      = 1'b1;
        err_code_d = 3'd1;
      end else begin
        rw_ok = 1'b1;
      end
    end
    if (cmd_act) begin
      if (in_flight && (bus.ba == b_ba_q)) begin
        err_d      = 1'b1;
        err_code_d = 3'd5;
      end else begin
        act_ok = 1'b1;
        if (tgt_open && !(ap_close && (bus.ba == b_ba_q))) begin
          err_d      = 1'b1;
          err_code_d = 3'd2;
        end
      end
    end
    if (cmd_pre) begin
      if (in_flight && (bus.addr[10] || (bus.ba == b_ba_q))) begin
        err_d      = 1'b1;
        err_code_d = 3'd5;
      end else begin
        pre_ok = 1'b1;
      end
    end
    if (cmd_ref && (|bank_open_q)) begin
      err_d      = 1'b1;
      err_code_d = 3'd4;
    end
  end
`else
  // Without checking every bank command executes; only a busy engine drops RD/WR.
  always_comb begin
    rw_ok      = (cmd_rd || cmd_wr) && !busy;
    act_ok     = cmd_act;
    pre_ok     = cmd_pre;
    err_d      = 1'b0;
    err_code_d = 3'd0;
  end
`endif

  // Burst engine next state plus bank/row bookkeeping.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    beat_d      = beat_q;
    b_ba_d      = b_ba_q;
    b_row_d     = b_row_q;
    b_col_d     = b_col_q;
    b_wr_d      = b_wr_q;
    b_ap_d      = b_ap_q;
    bank_open_d = bank_open_q;
    open_row_d  = open_row_q;
    wait_n      = RD_WAIT;
    case (state_q)
      S_IDLE: begin
        if (rw_ok) begin
          b_ba_d  = bus.ba;
          b_row_d = tgt_open ? open_row_q[bus.ba] : '0;
          b_col_d = bus.addr[COL_W-1:0];
          b_wr_d  = cmd_wr;
          b_ap_d  = bus.addr[10];
          beat_d  = 3'd0;
          wait_n  = cmd_wr ? WR_WAIT : RD_WAIT;
          if (wait_n == 4'd0) begin
            state_d = S_BURST;
          end else begin
            state_d = S_WAIT;
            cnt_d   = wait_n;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d = S_BURST;
          beat_d  = 3'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_BURST: begin
        beat_d = beat_q + 3'd1;
        if (beat_q == 3'd7) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Auto-precharge first so a same-cycle ACT to that bank takes precedence.
    if (ap_close) begin
      bank_open_d[b_ba_q] = 1'b0;
    end
    if (pre_ok) begin
      if (bus.addr[10]) begin
        bank_open_d = '0;
      end else begin
        bank_open_d[bus.ba] = 1'b0;
      end
    end
    if (act_ok) begin
      bank_open_d[bus.ba] = 1'b1;
      open_row_d[bus.ba]  = bus.addr[ROW_W-1:0];
    end
  end

  // Beat addressing and data-path outputs derived from the engine state.
  always_comb begin
    col_beat      = b_col_q;
    col_beat[2:0] = b_col_q[2:0] + beat_q;
    idx_full      = {b_ba_q, b_row_q, col_beat};
    mem_idx       = idx_full[MEM_AW-1:0];
    bus.dq_oe     = (state_q == S_BURST) && !b_wr_q;
    mem_we        = (state_q == S_BURST) && b_wr_q && !reset;
    bus.dq_out    = bus.dq_oe ? mem_q[mem_idx] : '0;
  end

  assign bank_open   = bank_open_q;
  assign err         = err_q;
  assign err_code    = err_code_q;
  assign unused_bits = ^{bus.addr, idx_full, in_flight, cmd_ref};

  // State register for the engine, bank tracking and error outputs.
  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      beat_q      <= '0;
      b_ba_q      <= '0;
      b_row_q     <= '0;
      b_col_q     <= '0;
      b_wr_q      <= 1'b0;
      b_ap_q      <= 1'b0;
      bank_open_q <= '0;
      err_q       <= 1'b0;
      err_code_q  <= 3'd0;
      for (int i = 0; i < BANKS; i++) begin
        open_row_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      beat_q      <= beat_d;
      b_ba_q      <= b_ba_d;
      b_row_q     <= b_row_d;
      b_col_q     <= b_col_d;
      b_wr_q      <= b_wr_d;
      b_ap_q      <= b_ap_d;
      bank_open_q <= bank_open_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      open_row_q  <= open_row_d;
    end
  end

  // Storage array; contents survive reset so data written before a reset stays readable.
  always_ff @(posedge cpu_clk) begin
    if (mem_we) begin
      mem_q[mem_idx] <= bus.dq_in;
    end
  end
endmodule

// File: tb/tb_ddr3_mem_responder.sv
// tb/tb_ddr3_mem_responder.sv - directed vector bench for ddr3_mem_responder (both DDR3_RESP_CHECK_EN builds)
module tb_ddr3_mem_responder;
`ifdef DDR3_RESP_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] ACT = 4'b0011;
  localparam logic [3:0] RD  = 4'b0101;
  localparam logic [3:0] WR  = 4'b0100;
  localparam logic [3:0] PRE = 4'b0010;
  localparam logic [3:0] REF = 4'b0001;

  typedef struct {
    logic [3:0]  cmd;
    logic [2:0]  ba;
    logic [13:0] addr;
    logic [15:0] din;
    logic        oe;
    logic [15:0] dq;
    logic        er;
    logic [2:0]  code;
    logic [7:0]  bopen;
  } vec_t;

  logic       cpu_clk;
  logic       reset;
  logic [7:0] bank_open;
  logic       err;
  logic [2:0] err_code;
  int         tests;
  int         fails;
  vec_t       vecs[$];

  ddr3_mem_responder_if #(.BANKS(8), .ROW_W(14), .COL_W(10), .DATA_W(16)) bus ();

  ddr3_mem_responder #(
    .BANKS(8), .ROW_W(14), .COL_W(10), .DATA_W(16), .CL(5), .CWL(5), .MEM_AW(10)
  ) dut (
    .cpu_clk   (cpu_clk),
    .reset     (reset),
    .bus       (bus),
    .bank_open (bank_open),
    .err       (err),
    .err_code  (err_code)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  task automatic add(input logic [3:0] c, input logic [2:0] b, input logic [13:0] a, input logic [15:0] d,
                     input logic oe, input logic [15:0] dq, input logic er, input logic [2:0] code,
                     input logic [7:0] bo);
    vec_t v;
    v.cmd = c; v.ba = b; v.addr = a; v.din = d;
    v.oe = oe; v.dq = dq; v.er = er; v.code = code; v.bopen = bo;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [3:0] c, input logic [2:0] b, input logic [13:0] a, input logic [15:0] d);
    {bus.cs_n, bus.ras_n, bus.cas_n, bus.we_n} = c;
    bus.ba    = b;
    bus.addr  = a;
    bus.dq_in = d;
  endtask

  task automatic step(input logic [3:0] c, input logic [2:0] b, input logic [13:0] a);
    @(negedge cpu_clk);
    drive(c, b, a, 16'h0);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, want);
    end
  endtask

  initial begin
    logic [7:0] bo;
    tests = 0;
    fails = 0;

    // c0..c26: write burst then read with wrapped start column
    add(ACT, 3'd2, 14'h155, 16'h0, 0, 16'h0, 0, 3'd0, 8'h00);
    add(WR,  3'd2, 14'h008, 16'h0, 0, 16'h0, 0, 3'd0, 8'h04);
    for (int k = 0; k < 4; k++) add(NOP, 3'd0, 14'h0, 16'h0, 0, 16'h0, 0, 3'd0, 8'h04);
    for (int k = 0; k < 8; k++) add(NOP, 3'd0, 14'h0, 16'h1000 + 16'(k), 0, 16'h0, 0, 3'd0, 8'h04);
    add(RD,  3'd2, 14'h00C, 16'h0, 0, 16'h0, 0, 3'd0, 8'h04);
    for (int k = 0; k < 4; k++) add(NOP, 3'd0, 14'h0, 16'h0, 0, 16'h0, 0, 3'd0, 8'h04);
    for (int k = 0; k < 8; k++) add(NOP, 3'd0, 14'h0, 16'h0, 1, 16'h1000 + 16'((4 + k) % 8), 0, 3'd0, 8'h04);
    // c27..c39: auto-precharge read
    add(RD,  3'd2, 14'h408, 16'h0, 0, 16'h0, 0, 3'd0, 8'h04);
    for (int k = 0; k < 4; k++) add(NOP, 3'd0, 14'h0, 16'h0, 0, 16'h0, 0, 3'd0, 8'h04);
    for (int k = 0; k < 8; k++) add(NOP, 3'd0, 14'h0, 16'h0, 1, 16'h1000 + 16'(k), 0, 3'd0, 8'h04);
    // c40..c53: read to closed bank (code 1, or serviced from row 0 when unchecked)
    add(RD,  3'd2, 14'h008, 16'h0, 0, 16'h0, 0, 3'd0, 8'h00);
    add(NOP, 3'd0, 14'h0, 16'h0, 0, 16'h0, CHK, CHK ? 3'd1 : 3'd0, 8'h00);
    for (int c = 42; c <= 53; c++)
      add(NOP, 3'd0, 14'h0, 16'h0, !CHK && c >= 45 && c <= 52,
          (!CHK && c >= 45 && c <= 52) ? 16'h1000 + 16'(c - 45) : 16'h0, 0, 3'd0, 8'h00);
    // c54..c75: second read while busy is dropped
    add(ACT, 3'd2, 14'h155, 16'h0, 0, 16'h0, 0, 3'd0, 8'h00);
    add(RD,  3'd2, 14'h008, 16'h0, 0, 16'h0, 0, 3'd0, 8'h04);
    add(NOP, 3'd0, 14'h0, 16'h0, 0, 16'h0, 0, 3'd0, 8'h04);
    add(NOP, 3'd0, 14'h0, 16'h0, 0, 16'h0, 0, 3'd0, 8'h04);
    add(RD,  3'd2, 14'h000, 16'h0, 0, 16'h0, 0, 3'd0, 8'h04);
    add(NOP, 3'd0, 14'h0, 16'h0, 0, 16'h0, CHK, CHK ? 3'd3 : 3'd0, 8'h04);
    for (int k = 0; k < 8; k++) add(NOP, 3'd0, 14'h0, 16'h0, 1, 16'h1000 + 16'(k), 0, 3'd0, 8'h04);
    for (int k = 0; k < 8; k++) add(NOP, 3'd0, 14'h0, 16'h0, 0, 16'h0, 0, 3'd0, 8'h04);
    // c76..c80: double ACT, REF with open bank, precharge all
    add(ACT, 3'd0, 14'h001, 16'h0, 0, 16'h0, 0, 3'd0, 8'h04);
    add(ACT, 3'd0, 14'h002, 16'h0, 0, 16'h0, 0, 3'd0, 8'h05);
    add(REF, 3'd0, 14'h000, 16'h0, 0, 16'h0, CHK, CHK ? 3'd2 : 3'd0, 8'h05);
    add(PRE, 3'd0, 14'h400, 16'h0, 0, 16'h0, CHK, CHK ? 3'd4 : 3'd0, 8'h05);
    add(NOP, 3'd0, 14'h0, 16'h0, 0, 16'h0, 0, 3'd0, 8'h00);
    // c81..c95: PRE to the bank of an in-flight burst
    bo = CHK ? 8'h02 : 8'h00;
    add(ACT, 3'd1, 14'h000, 16'h0, 0, 16'h0, 0, 3'd0, 8'h00);
    add(RD,  3'd1, 14'h008, 16'h0, 0, 16'h0, 0, 3'd0, 8'h02);
    add(PRE, 3'd1, 14'h000, 16'h0, 0, 16'h0, 0, 3'd0, 8'h02);
    add(NOP, 3'd0, 14'h0, 16'h0, 0, 16'h0, CHK, CHK ? 3'd5 : 3'd0, bo);
    add(NOP, 3'd0, 14'h0, 16'h0, 0, 16'h0, 0, 3'd0, bo);
    add(NOP, 3'd0, 14'h0, 16'h0, 0, 16'h0, 0, 3'd0, bo);
    for (int k = 0; k < 8; k++) add(NOP, 3'd0, 14'h0, 16'h0, 1, 16'h1000 + 16'(k), 0, 3'd0, bo);
    add(NOP, 3'd0, 14'h0, 16'h0, 0, 16'h0, 0, 3'd0, bo);

    reset = 1'b1;
    drive(NOP, 3'd0, 14'h0, 16'h0);
    repeat (3) @(posedge cpu_clk);
    @(negedge cpu_clk);
    chk("reset_state", {3'b0, bus.dq_oe, bus.dq_out, err, err_code, bank_open}, 32'h0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      @(negedge cpu_clk);
      chk($sformatf("vec%0d", i),
          {3'b0, bus.dq_oe, vecs[i].oe ? bus.dq_out : 16'h0, err, err_code, bank_open},
          {3'b0, vecs[i].oe, vecs[i].oe ? vecs[i].dq : 16'h0, vecs[i].er, vecs[i].code, vecs[i].bopen});
      drive(vecs[i].cmd, vecs[i].ba, vecs[i].addr, vecs[i].din);
    end

    // Reset on beat 3 of a read burst, then confirm storage survived
    step(ACT, 3'd3, 14'h007);
    step(RD,  3'd3, 14'h00C);
    for (int k = 0; k < 4; k++) step(NOP, 3'd0, 14'h0);
    for (int k = 0; k < 4; k++) begin
      step(NOP, 3'd0, 14'h0);
      chk($sformatf("rst_beat%0d", k), {15'h0, bus.dq_oe, bus.dq_out}, {15'h0, 1'b1, 16'h1004 + 16'(k)});
    end
    reset = 1'b1;
    step(NOP, 3'd0, 14'h0);
    chk("rst_oe_low", {31'h0, bus.dq_oe}, 32'h0);
    chk("rst_bank_open", {24'h0, bank_open}, 32'h0);
    chk("rst_err", {28'h0, err, err_code}, 32'h0);
    reset = 1'b0;
    step(ACT, 3'd3, 14'h007);
    step(RD,  3'd3, 14'h008);
    for (int k = 0; k < 4; k++) step(NOP, 3'd0, 14'h0);
    for (int k = 0; k < 2; k++) begin
      step(NOP, 3'd0, 14'h0);
      chk($sformatf("post_rst_beat%0d", k), {15'h0, bus.dq_oe, bus.dq_out}, {15'h0, 1'b1, 16'h1000 + 16'(k)});
    end
    chk("post_rst_bank_open", {24'h0, bank_open}, 32'h08);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ddr3_mem_responder.md
# ddr3_mem_responder

Synthesizable DDR3 device-side responder: the memory end of the controller's memory command/data bus. It decodes the command pins, tracks open rows per bank, and services BL8 read/write bursts from a small internal storage array with fixed CAS/CAS-write latencies. It runs beside `ddr3_mem_cont` in simulation and FPGA bring-up, with protocol checking that flags illegal controller sequences.

## Interface
- `BANKS`, 8: number of banks; `BA_W` = $clog2(BANKS)
- `ROW_W`, 14: row address width
- `COL_W`, 10: column address width; must be ≥ 11 is NOT required, `addr` is max(ROW_W, COL_W, 11) bits
- `DATA_W`, 16: dq width
- `CL`, 5: read latency in cycles, 2..15
- `CWL`, 5: write latency in cycles, 1..15
- `MEM_AW`, 10: storage depth is 2**MEM_AW words of DATA_W
---
- `cpu_clk` in 1: sole clock, all logic on rising edge
- `reset` in 1: synchronous, active-high
- `cs_n`, `ras_n`, `cas_n`, `we_n` in 1 each: command pins
- `ba` in BA_W: bank address
- `addr` in ADDR_W: row (ACT) / column + addr[10] auto-precharge (RD/WR) / addr[10] all-banks (PRE)
- `dq_in` in DATA_W: write data from controller
- `dq_out` out DATA_W: read data
- `dq_oe` out 1: high on every cycle `dq_out` carries a read beat
- `bank_open` out BANKS: per-bank row-open status
- `err` out 1: one-cycle protocol-error pulse
- `err_code` out 3: cause, valid when `err`=1

## Operation
- Decode {cs_n,ras_n,cas_n,we_n}: 1xxx DESEL, 0111 NOP, 0011 ACT, 0101 RD, 0100 WR, 0010 PRE, 0001 REF, 0000 MRS (accepted, no effect), 0110 ZQ (no effect).
- ACT: `bank_open[ba]`←1, `open_row[ba]`←addr[ROW_W-1:0]. PRE: closes `ba`, or all banks if addr[10]=1. REF: no state change.
- Storage index = low MEM_AW bits of {ba, open_row[ba], col}; no address collisions are reported.
- Burst engine FSM: IDLE → WAIT (count CL-1 or CWL-1 cycles) → BURST (8 beats) → IDLE. RD/WR accepted only in IDLE; latches ba, row, col, direction, auto-precharge.
- Burst order: sequential, aligned; beat k uses col[2:0] = (start col[2:0] + k) mod 8, upper col bits fixed (wrap within 8-aligned block).
- Read beats: `dq_out` = mem[index], `dq_oe`=1. Write beats: mem[index] ← `dq_in`.
- Auto-precharge (addr[10]=1 at RD/WR): bank closes on the cycle after the last beat.
- Error codes: 1 RD/WR to closed bank; 2 ACT to open bank; 3 RD/WR while engine not IDLE; 4 REF with any bank open; 5 ACT/PRE to the bank of an in-flight burst.
- Erroneous RD/WR (codes 1, 3) are dropped; ACT code 2 overwrites row; code 4 REF proceeds; code 5 command dropped.
- Simultaneous: command in same cycle as last burst beat sees engine non-IDLE → code 3. Auto-precharge closing and an ACT to the same bank on that cycle: ACT wins.

## Timing
- RD at cycle T: beats on T+CL … T+CL+7; `dq_oe` low outside. WR at T: `dq_in` sampled T+CWL … T+CWL+7.
- Minimum RD/WR spacing: CL+8 (read) or CWL+8 (write) cycles.
- `bank_open` updates the cycle after ACT/PRE. `err`/`err_code` registered: asserted cycle T+1 for offending command at T.
- Reset values: `dq_out`=0, `dq_oe`=0, `bank_open`=0, `err`=0, `err_code`=0, FSM IDLE, open rows 0. Storage contents are not reset.
- Reset mid-burst: burst aborted immediately, `dq_oe` low next cycle, partial writes remain in storage.

## Configuration
- `DDR3_RESP_CHECK_EN` defined: error detection and dropping as above.
- Undefined: `err`, `err_code` tied 0; RD/WR to closed bank uses row 0; RD/WR while busy still silently dropped; ACT/PRE during burst executed.

## Test plan
- ACT ba=2 row=0x155; WR col=0x008 data 0x1000..0x1007 at T+CWL → RD col=0x00C returns 0x1004,05,06,07,00,01,02,03 starting exactly T'+CL.
- RD with addr[10]=1 → 8 beats, `bank_open[2]` falls cycle after last beat; next RD to bank 2 → `err`=1, code 1, no `dq_oe`.
- Second RD issued 3 cycles after first → code 3, only one 8-beat burst on `dq_out`.
- ACT bank 0 twice → code 2; REF with bank 0 open → code 4; PRE addr[10]=1 → `bank_open`=0.
- Assert `reset` on beat 3 of read burst → `dq_oe`=0 next cycle, `bank_open`=0, subsequent ACT/RD returns previously written data.
- With `DDR3_RESP_CHECK_EN` undefined, repeat code-1 sequence → `err` stays 0, read serviced from row 0.
